alu_seq: RTL
============

# alu_seq

Parametrised, clocked successor to the 16-bit combinational MyALU/MyALU2 pair. It keeps the same 3-bit opcode space and the INm/INn/INc operands with OUTf/ZER/NEG results. It adds width parametrisation, registered outputs, a start/busy/done handshake, and two iterative multi-cycle operations: unsigned multiply (shift-add) and unsigned divide (restoring). It sits between the datapath register file and the result bus, and its flags feed the branch logic.

## Interface
- WIDTH, 16, operand/result width; minimum 4.
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- OPC  in  3  opcode; latched with start.
- INm, INn  in  WIDTH  operands; latched with start.
- INc  in  1  carry/borrow in; latched with start.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse; results valid and updated this cycle.
- OUTf  out  WIDTH  primary result (low product half, quotient).
- OUTh  out  WIDTH  high product half or remainder; 0 for other ops.
- COUT  out  1  carry (ADD) or borrow (SUB); 0 for other ops.
- ZER  out  1  result is zero.
- NEG  out  1  OUTf[WIDTH-1].
- DVZ  out  1  divide-by-zero flag; 0 for other ops.

## Operation
- Opcodes:
  - 000 ADD: {COUT,OUTf}=INm+INn+INc.
  - 001 SUB: {COUT,OUTf}=INm-INn-INc. COUT=1 on borrow.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT: ~INm.
  - 110 MUL: {OUTh,OUTf}=INm*INn, unsigned.
  - 111 DIV: OUTf=INm/INn, OUTh=INm%INn, unsigned.
- States: IDLE and RUN.
  - IDLE: start with a single-cycle opcode, or DIV with INn=0, registers the result at that edge and stays in IDLE.
  - IDLE: start with MUL, or DIV with INn≠0, latches the operands, loads the counter with WIDTH, and moves to RUN.
  - RUN: one iteration per edge and the counter decrements. At the final iteration the result is written, done pulses, and the state returns to IDLE.
- start while busy=1 is ignored. Operands and opcode are not re-sampled.
- Output flags:
  - ZER: OUTf==0 for single-cycle ops. {OUTh,OUTf}==0 for MUL. OUTf==0 for DIV.
  - NEG: always OUTf MSB.
- Divide by zero: OUTf is all ones, OUTh=INm, DVZ=1, ZER=0. It completes as a single-cycle op.
- Result outputs hold their last value between completions. Only done is a pulse.
- Reset, asynchronous and valid at any time, including mid-RUN:
  - state returns to IDLE; counter cleared.
  - OUTf and OUTh go to 0.
  - busy, done, COUT, NEG and DVZ go to 0.
  - ZER goes to 0.
  - Any partial MUL/DIV is discarded with no done pulse.

## Timing
- Let start be sampled high at edge k.
- Single-cycle ops:
  - Results and done=1 become visible after edge k; done drops after edge k+1 unless there is a new start.
  - Back-to-back single-cycle starts on consecutive edges are accepted with throughput 1/cycle.
- MUL/DIV:
  - busy=1 after edge k.
  - Iterations run at edges k+1 … k+WIDTH.
  - At edge k+WIDTH the results are written, done=1, and busy=0.
  - Latency is WIDTH cycles.
- start high at edge k+WIDTH is ignored because the state is still RUN. The next accept is at edge k+WIDTH+1.
- Arithmetic widths:
  - ADD/SUB use a WIDTH+1 adder.
  - MUL uses a 2·WIDTH accumulator.
  - DIV uses a WIDTH+1 partial remainder.
- No combinational path from inputs to outputs.

## Structure
- Package alu_pkg holds:
  - the opcode enum op_e (OP_ADD…OP_DIV);
  - the state enum state_e (S_IDLE, S_RUN);
  - the helper function is_multicycle(op, n).
- Sub-module alu_muldiv #(WIDTH) holds the iterative shift-add/restoring engine, its counter and its operand registers. Its interface is load, op_div, a, b, busy and fin, plus hi/lo results.
- The top level holds the single-cycle logic, the output registers, flag generation, and the handshake FSM.

## Test plan
All scenarios use WIDTH=16.
- ADD 16'hFFFF + 16'h0001, INc=0 → after 1 cycle: OUTf=0, COUT=1, ZER=1, NEG=0, one done pulse.
- SUB 16'h0003 − 16'h0005, INc=0 → OUTf=16'hFFFE, COUT=1, NEG=1. Then NOT 16'h00FF on the next cycle → OUTf=16'hFF00, done high on both cycles.
- MUL 16'h1234 × 16'h0010:
  - busy for 16 cycles;
  - done pulses exactly 16 cycles after the accept edge;
  - OUTh=16'h0001, OUTf=16'h2340;
  - a start pulsed at cycle 5 is ignored.
- DIV 100 ÷ 7 → OUTf=14, OUTh=2, DVZ=0 after 16 cycles. DIV 16'h1234 ÷ 0 → 1-cycle latency, OUTf=16'hFFFF, OUTh=16'h1234, DVZ=1.
- rstn low at cycle 8 of a MUL → all outputs 0 immediately (asynchronously), no done pulse. After release, ADD 2+3 completes correctly with OUTf=5.
- Random sweep over all 8 opcodes for 2000 iterations, compared against a reference model. Repeat at WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings,
// plus the decision of which requests take the iterative engine.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_MUL = 3'b110,
        OP_DIV = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    // Divide by zero is answered immediately, so only a real divide iterates.
    function automatic logic is_multicycle(input op_e op, input logic n_nz);
        return (op == OP_MUL) || ((op == OP_DIV) && n_nz);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (MSB-first shift-add) and restoring divide.
// hi/lo present the value the next iteration will write, so fin marks the edge to capture them.
module alu_muldiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt;
    logic               div_q;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   operand_b;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_nxt;
    logic [WIDTH-1:0]   lo_nxt;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] acc_nxt;

    // For MUL {hi_q,lo_q} is the 2*WIDTH accumulator; for DIV hi_q is the
    // partial remainder and lo_q shifts the dividend out as quotient bits enter.
    always_comb begin
        hi_nxt  = hi_q;
        lo_nxt  = lo_q;
        shifted = {hi_q, lo_q[WIDTH-1]};
        trial   = shifted - {1'b0, operand_b};
        acc_nxt = {hi_q, lo_q} << 1;
        if (mplier[WIDTH-1])
            acc_nxt = acc_nxt + {{WIDTH{1'b0}}, operand_b};
        if (div_q) begin
            hi_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            {hi_nxt, lo_nxt} = acc_nxt;
        end
    end

    assign busy = (cnt != '0);
    assign fin  = (cnt == CW'(1));
    assign hi   = hi_nxt;
    assign lo   = lo_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            div_q     <= 1'b0;
            mplier    <= '0;
            operand_b <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (load) begin
            cnt       <= CW'(WIDTH);
            div_q     <= op_div;
            mplier    <= a;
            operand_b <= b;
            hi_q      <= '0;
            lo_q      <= op_div ? a : '0;
        end else if (busy) begin
            cnt    <= cnt - CW'(1);
            mplier <= mplier << 1;
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with start/busy/done handshake: logic ops and divide-by-zero
// finish in one cycle, MUL/DIV run WIDTH iterations in alu_muldiv.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       OPC,
    input  logic [WIDTH-1:0] INm,
    input  logic [WIDTH-1:0] INn,
    input  logic             INc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] OUTf,
    output logic [WIDTH-1:0] OUTh,
    output logic             COUT,
    output logic             ZER,
    output logic             NEG,
    output logic             DVZ
);

    state_e           state;
    state_e           state_nxt;
    op_e              op;
    logic             run_div;
    logic             eng_load;
    logic             eng_busy;
    logic             eng_fin;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;
    logic             wr;
    logic [WIDTH-1:0] f_d;
    logic [WIDTH-1:0] h_d;
    logic             co_d;
    logic             z_d;
    logic             dz_d;
    logic [WIDTH:0]   add_r;
    logic [WIDTH:0]   sub_r;

    assign op = op_e'(OPC);

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rstn   (rstn),
        .load   (eng_load),
        .op_div (op == OP_DIV),
        .a      (INm),
        .b      (INn),
        .busy   (eng_busy),
        .fin    (eng_fin),
        .hi     (eng_hi),
        .lo     (eng_lo)
    );

    always_comb begin
        state_nxt = state;
        eng_load  = 1'b0;
        wr        = 1'b0;
        f_d       = '0;
        h_d       = '0;
        co_d      = 1'b0;
        z_d       = 1'b0;
        dz_d      = 1'b0;
        add_r     = {1'b0, INm} + {1'b0, INn} + {{WIDTH{1'b0}}, INc};
        sub_r     = {1'b0, INm} - {1'b0, INn} - {{WIDTH{1'b0}}, INc};
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_multicycle(op, |INn)) begin
                        eng_load  = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        wr = 1'b1;
                        unique case (op)
                            OP_ADD: {co_d, f_d} = add_r;
                            OP_SUB: {co_d, f_d} = sub_r;
                            OP_AND: f_d = INm & INn;
                            OP_OR:  f_d = INm | INn;
                            OP_XOR: f_d = INm ^ INn;
                            OP_NOT: f_d = ~INm;
                            OP_DIV: begin
                                f_d  = '1;
                                h_d  = INm;
                                dz_d = 1'b1;
                            end
                            default: ;
                        endcase
                        z_d = (f_d == '0);
                    end
                end
            end
            S_RUN: begin
                if (eng_fin) begin
                    wr        = 1'b1;
                    state_nxt = S_IDLE;
                    f_d       = eng_lo;
                    h_d       = eng_hi;
                    z_d       = run_div ? (eng_lo == '0) : ({eng_hi, eng_lo} == '0);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Results hold between completions; only done is a pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            run_div <= 1'b0;
            done    <= 1'b0;
            OUTf    <= '0;
            OUTh    <= '0;
            COUT    <= 1'b0;
            ZER     <= 1'b0;
            DVZ     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= wr;
            if (eng_load)
                run_div <= (op == OP_DIV);
            if (wr) begin
                OUTf <= f_d;
                OUTh <= h_d;
                COUT <= co_d;
                ZER  <= z_d;
                DVZ  <= dz_d;
            end
        end
    end

    assign busy = eng_busy;
    assign NEG  = OUTf[WIDTH-1];

endmodule
